cic_comb_seq: RTL

CIC_COMB_SEQ -- requirements
Module: cic_comb_seq

---
 rtl/cic_pkg.sv | 14 +
 rtl/ce_pipe.sv | 35 +++
 rtl/cic_comb_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC comb-chain sequencer: FSM state encoding and
// default geometry constants.
package cic_pkg;

    localparam int NSTAGE_DEF = 5;
    localparam int RATE_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CH0  = 2'd1,
        CH1  = 2'd2
    } cic_state_e;

endpackage

// File: rtl/ce_pipe.sv
// Two-lane enable delay line: lane 0 carries channel-0 enables, lane 1 carries
// channel-1 enables, advancing one comb stage per clock.
module ce_pipe #(
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       d,
    output logic [DEPTH-1:0] q0,
    output logic [DEPTH-1:0] q1
);

    logic [DEPTH-1:0] q0_r;
    logic [DEPTH-1:0] q1_r;
    logic [DEPTH:0]   sh0_s;
    logic [DEPTH:0]   sh1_s;

    assign sh0_s = {q0_r, d[0]};
    assign sh1_s = {q1_r, d[1]};

    // Shift both lanes towards the last comb stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            q0_r <= {DEPTH{1'b0}};
            q1_r <= {DEPTH{1'b0}};
        end else begin
            q0_r <= sh0_s[DEPTH-1:0];
            q1_r <= sh1_s[DEPTH-1:0];
        end
    end

    assign q0 = q0_r;
    assign q1 = q1_r;

endmodule

// File: rtl/cic_comb_seq.sv
// Decimation sequencer for a shared 2-channel CIC comb chain: counts integrator
// strobes, and on each decimation hit walks an I then Q enable down the stages.
module cic_comb_seq
    import cic_pkg::*;
#(
    parameter int NSTAGE   = NSTAGE_DEF,
    parameter int RW       = RATE_W,
    parameter int RST_RATE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_stb,
    input  logic [RW-1:0]     rate,
    input  logic              rate_ld,
    output logic              sel,
    output logic [NSTAGE-1:0] ce0,
    output logic [NSTAGE-1:0] ce1,
    output logic              out_vld,
    output logic              out_ch,
    output logic              ovf
);

    localparam logic [RW-1:0] ONE_C   = RW'(1'b1);
    localparam logic [RW-1:0] TWO_C   = RW'(2'd2);
    localparam logic [RW-1:0] RST_ACT = (RST_RATE < 2) ? TWO_C : RW'(RST_RATE);

    // Rates below 2 cannot fit an I/Q pair between hits, so they are raised to 2.
    function automatic logic [RW-1:0] clamp_rate(input logic [RW-1:0] r);
        if (r < TWO_C) begin
            return TWO_C;
        end else begin
            return r;
        end
    endfunction

    cic_state_e    state_r;
    cic_state_e    next_state_s;
    logic [RW-1:0] rate_act_r;
    logic [RW-1:0] cnt_r;
    logic [RW-1:0] load_rate_s;
    logic          hit_s;
    logic          accept_s;
    logic          sel_r;
    logic          ovf_r;
    logic          out_vld_r;
    logic          out_ch_r;
    logic [1:0]    ce_d_s;

    // Decode the decimation hit and the next sequencer state.
    always_comb begin
        load_rate_s  = clamp_rate(rate);
        hit_s        = in_stb & ~rate_ld & (cnt_r == {RW{1'b0}});
        accept_s     = hit_s & (state_r == IDLE);
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = CH0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CH0:     next_state_s = CH1;
            CH1:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
        ce_d_s = {(next_state_s == CH1), (next_state_s == CH0)};
    end

    // Rate register, strobe down-counter and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_act_r <= RST_ACT;
            cnt_r      <= RST_ACT - ONE_C;
            ovf_r      <= 1'b0;
        end else if (rate_ld) begin
            rate_act_r <= load_rate_s;
            cnt_r      <= load_rate_s - ONE_C;
            ovf_r      <= 1'b0;
        end else if (in_stb) begin
            if (cnt_r == {RW{1'b0}}) begin
                cnt_r <= rate_act_r - ONE_C;
                if (state_r != IDLE) begin
                    ovf_r <= 1'b1;
                end else begin
                    ovf_r <= ovf_r;
                end
            end else begin
                cnt_r <= cnt_r - ONE_C;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sequencer state and registered comb input mux select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sel_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            sel_r   <= (next_state_s == CH1);
        end
    end

    ce_pipe #(
        .DEPTH (NSTAGE)
    ) u_ce_pipe (
        .clk (clk),
        .rst (rst),
        .d   (ce_d_s),
        .q0  (ce0),
        .q1  (ce1)
    );

    // The last stage's enable means its output register holds a fresh sample next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_r <= 1'b0;
            out_ch_r  <= 1'b0;
        end else begin
            out_vld_r <= ce0[NSTAGE-1] | ce1[NSTAGE-1];
            out_ch_r  <= ce1[NSTAGE-1];
        end
    end

    assign sel     = sel_r;
    assign ovf     = ovf_r;
    assign out_vld = out_vld_r;
    assign out_ch  = out_ch_r;

endmodule
